zz_reorder_ctrl: RTL

Ping-pong reorder controller that accepts coefficient blocks in raster order and emits them in zigzag order. It owns two COL×ROW banks of DW-bit storage. It steps a stallable zigzag scan generator to address the draining bank, so one bank fills while the other drains. It sits between the 2-D transform output and the entropy-coding stage.

---
 rtl/zz_pkg.sv | 20 ++
 rtl/zz_scan_gen.sv | 72 +++++++
 rtl/zz_reorder_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/zz_pkg.sv
// Shared types for the zigzag reorder controller: bank and read-FSM states,
// plus the block-size helper.
package zz_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    DRAIN = 2'd2
  } bank_state_t;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } rd_state_t;

  function automatic int blk_size(input int col, input int row);
    return col * row;
  endfunction

endpackage

// File: rtl/zz_scan_gen.sv
// Stallable zigzag scan generator over a COL x ROW block; clear wins over step.
// last is registered alongside the coordinates it describes.
module zz_scan_gen #(
  parameter  int COL = 8,
  parameter  int ROW = 8,
  localparam int XW  = $clog2(COL),
  localparam int YW  = $clog2(ROW)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          step,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          last
);

  localparam logic [XW-1:0] XMAX = XW'(COL - 1);
  localparam logic [YW-1:0] YMAX = YW'(ROW - 1);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          last_q, last_d;

  always_comb begin
    x_d = x_q;
    y_d = y_q;
    if (clear) begin
      x_d = '0;
      y_d = '0;
    end else if (step) begin
      // Even diagonals run up-right, odd diagonals run down-left.
      if ((x_q[0] ^ y_q[0]) == 1'b0) begin
        if (x_q == XMAX) begin
          y_d = y_q + 1'b1;
        end else if (y_q == '0) begin
          x_d = x_q + 1'b1;
        end else begin
          x_d = x_q + 1'b1;
          y_d = y_q - 1'b1;
        end
      end else begin
        if (y_q == YMAX) begin
          x_d = x_q + 1'b1;
        end else if (x_q == '0) begin
          y_d = y_q + 1'b1;
        end else begin
          x_d = x_q - 1'b1;
          y_d = y_q + 1'b1;
        end
      end
    end
    last_d = (x_d == XMAX) && (y_d == YMAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q    <= '0;
      y_q    <= '0;
      last_q <= 1'b0;
    end else begin
      x_q    <= x_d;
      y_q    <= y_d;
      last_q <= last_d;
    end
  end

  assign x    = x_q;
  assign y    = y_q;
  assign last = last_q;

endmodule

// File: rtl/zz_reorder_ctrl.sv
// Ping-pong raster-to-zigzag reorder buffer: one bank fills from the transform
// while the other drains in zigzag order to the entropy coder.
module zz_reorder_ctrl
  import zz_pkg::*;
#(
  parameter int DW  = 12,
  parameter int COL = 8,
  parameter int ROW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          dbg_rd_state,
  output logic [3:0]    dbg_bank_state
);

  localparam int N  = blk_size(COL, ROW);
  localparam int AW = $clog2(N);
  localparam int XW = $clog2(COL);
  localparam int YW = $clog2(ROW);

  // Handshake: a beat moves on a rising edge where valid and ready are both 1;
  // valid never waits on ready, and a held beat keeps its data stable.

  bank_state_t   bank_q [2];
  bank_state_t   bank_d [2];
  logic          wr_bank_q, wr_bank_d;
  logic          rd_bank_q, rd_bank_d;
  logic [AW-1:0] wa_q, wa_d;
  rd_state_t     rd_q, rd_d;

  logic [DW-1:0] mem_q [2][N];

  logic          wr_fire, wr_done;
  logic          rd_fire, rd_done;
  logic          start, restart;
  logic          scan_clear;
  logic [XW-1:0] scan_x;
  logic [YW-1:0] scan_y;
  logic          scan_last;

  assign in_ready  = (bank_q[wr_bank_q] == EMPTY);
  assign out_valid = (rd_q == STREAM);
  assign out_last  = out_valid & scan_last;
  // Gated so the never-cleared storage cannot leak onto the bus when idle.
  assign out_data  = out_valid ? mem_q[rd_bank_q][{scan_y, scan_x}] : '0;

  assign wr_fire = in_valid & in_ready;
  assign wr_done = wr_fire && (wa_q == AW'(N - 1));
  assign rd_fire = out_valid & out_ready;
  assign rd_done = rd_fire & scan_last;
  assign start   = (rd_q == IDLE) && (bank_q[rd_bank_q] == FULL);
  assign restart = rd_done && (bank_q[~rd_bank_q] == FULL);

  // The write and read sides always touch different banks, so their updates
  // on the same edge never collide.
  always_comb begin
    bank_d[0] = bank_q[0];
    bank_d[1] = bank_q[1];
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wa_d      = wa_q;
    rd_d      = rd_q;

    if (wr_fire) begin
      wa_d = wr_done ? '0 : wa_q + 1'b1;
    end
    if (wr_done) begin
      bank_d[wr_bank_q] = FULL;
      wr_bank_d         = ~wr_bank_q;
    end

    case (rd_q)
      IDLE: begin
        if (start) begin
          rd_d              = STREAM;
          bank_d[rd_bank_q] = DRAIN;
        end
      end
      STREAM: begin
        if (rd_done) begin
          bank_d[rd_bank_q] = EMPTY;
          rd_bank_d         = ~rd_bank_q;
          if (restart) begin
            bank_d[~rd_bank_q] = DRAIN;
          end else begin
            rd_d = IDLE;
          end
        end
      end
      default: rd_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_q[0] <= EMPTY;
      bank_q[1] <= EMPTY;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wa_q      <= '0;
      rd_q      <= IDLE;
    end else begin
      bank_q[0] <= bank_d[0];
      bank_q[1] <= bank_d[1];
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wa_q      <= wa_d;
      rd_q      <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[wr_bank_q][wa_q] <= in_data;
    end
  end

  // Clearing on the last beat as well leaves the scan at (0,0) for a restart.
  assign scan_clear = start | rd_done;

  zz_scan_gen #(
    .COL(COL),
    .ROW(ROW)
  ) u_scan (
    .clk  (clk),
    .rst  (rst),
    .clear(scan_clear),
    .step (rd_fire),
    .x    (scan_x),
    .y    (scan_y),
    .last (scan_last)
  );

  assign dbg_rd_state   = rd_q;
  assign dbg_bank_state = {bank_q[1], bank_q[0]};

endmodule
